dmem_access_arbiter: RTL and testbench

//  Shares the byte-addressed DataMemory between two requesters: the pipeline MEM stage (P) and the program loader/test port (L).

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_rr_arbiter.sv | 33 +++
 rtl/dmem_access_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dmem_access_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the DataMemory access arbiter: Size codes, FSM states,
// requester ids and the byte count of each access size.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'b00,
        SZ_HALFWORD = 2'b01,
        SZ_WORD     = 2'b10,
        SZ_ILLEGAL  = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    // Requester ids double as bit positions in the request/grant vectors.
    localparam logic PORT_P = 1'b0;
    localparam logic PORT_L = 1'b1;

    function automatic logic [2:0] bytes_of(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE:     n = 3'd1;
            SZ_HALFWORD: n = 3'd2;
            SZ_WORD:     n = 3'd4;
            default:     n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_rr_arbiter.sv
// Two-way round-robin arbiter: the requester that did not win last time wins
// a contention. Grant is combinational; the history advances on request.
module dmem_rr_arbiter
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_gnt;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_gnt == PORT_L) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= PORT_L;
        end else if (advance && (|req)) begin
            last_gnt <= gnt[PORT_L] ? PORT_L : PORT_P;
        end
    end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares DataMemory between the MEM stage (P) and the loader port (L), one access per grant.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module dmem_access_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 512
)
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              P_Req,
    input  logic              P_RW,
    input  logic              P_SignExt,
    input  logic [1:0]        P_Size,
    input  logic [ADDR_W-1:0] P_Addr,
    input  logic [DATA_W-1:0] P_WData,
    output logic              P_Ack,
    output logic              P_Err,
    output logic [DATA_W-1:0] P_RData,
    input  logic              L_Req,
    input  logic              L_RW,
    input  logic              L_SignExt,
    input  logic [1:0]        L_Size,
    input  logic [ADDR_W-1:0] L_Addr,
    input  logic [DATA_W-1:0] L_WData,
    output logic              L_Ack,
    output logic              L_Err,
    output logic [DATA_W-1:0] L_RData,
    output logic              MemEnable,
    output logic              MemReadWrite,
    output logic              MemSignExt,
    output logic [1:0]        MemSize,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemDataIn,
    input  logic [DATA_W-1:0] MemDataOut,
    output logic              Busy
);

    state_t            state;
    logic              gnt_port;
    logic [1:0]        req_p0;
    logic [1:0]        gnt_p0;
    logic              advance;

    logic              win_port;
    logic              win_rw;
    logic              win_se;
    logic [1:0]        win_size;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [31:0]       end_addr;
    logic              bad;

    assign req_p0  = {L_Req, P_Req};
    assign advance = (state == ST_IDLE) && (|req_p0);
    assign Busy    = (state != ST_IDLE);

    dmem_rr_arbiter u_arb (
        .clk     (Clk),
        .rst     (Reset),
        .req     (req_p0),
        .advance (advance),
        .gnt     (gnt_p0)
    );

    always_comb begin
        win_port  = PORT_P;
        win_rw    = P_RW;
        win_se    = P_SignExt;
        win_size  = P_Size;
        win_addr  = P_Addr;
        win_wdata = P_WData;
        if (gnt_p0[PORT_L]) begin
            win_port  = PORT_L;
            win_rw    = L_RW;
            win_se    = L_SignExt;
            win_size  = L_Size;
            win_addr  = L_Addr;
            win_wdata = L_WData;
        end
    end

    // Access legality: illegal size, or any byte of the access past the end of memory.
    always_comb begin
        end_addr = 32'(win_addr) + 32'(bytes_of(win_size));
        bad      = (win_size == SZ_ILLEGAL) || (end_addr > 32'(MEM_BYTES));
`ifdef DMEM_ALIGN_CHECK_EN
        if ((win_size == SZ_HALFWORD) && win_addr[0]) begin
            bad = 1'b1;
        end
        if ((win_size == SZ_WORD) && (win_addr[1:0] != 2'b00)) begin
            bad = 1'b1;
        end
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= ST_IDLE;
            gnt_port     <= PORT_P;
            MemEnable    <= 1'b0;
            MemReadWrite <= 1'b0;
            MemSignExt   <= 1'b0;
            MemSize      <= 2'b00;
            MemAddress   <= '0;
            MemDataIn    <= '0;
            P_Ack        <= 1'b0;
            P_Err        <= 1'b0;
            P_RData      <= '0;
            L_Ack        <= 1'b0;
            L_Err        <= 1'b0;
            L_RData      <= '0;
        end else begin
            // Response outputs are single-cycle; they only carry a value in RESP.
            P_Ack   <= 1'b0;
            P_Err   <= 1'b0;
            P_RData <= '0;
            L_Ack   <= 1'b0;
            L_Err   <= 1'b0;
            L_RData <= '0;
            case (state)
                ST_IDLE: begin
                    if (advance) begin
                        gnt_port <= win_port;
                        if (bad) begin
                            state <= ST_RESP;
                            if (win_port == PORT_P) begin
                                P_Ack <= 1'b1;
                                P_Err <= 1'b1;
                            end else begin
                                L_Ack <= 1'b1;
                                L_Err <= 1'b1;
                            end
                        end else begin
                            state        <= ST_ACCESS;
                            MemEnable    <= 1'b1;
                            MemReadWrite <= win_rw;
                            MemSignExt   <= win_se;
                            MemSize      <= win_size;
                            MemAddress   <= win_addr;
                            MemDataIn    <= win_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    state     <= ST_RESP;
                    MemEnable <= 1'b0;
                    if (gnt_port == PORT_P) begin
                        P_Ack   <= 1'b1;
                        P_RData <= MemReadWrite ? '0 : MemDataOut;
                    end else begin
                        L_Ack   <= 1'b1;
                        L_RData <= MemReadWrite ? '0 : MemDataOut;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    MemEnable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Directed bench for dmem_access_arbiter with a little-endian byte memory model.
module tb_dmem_access_arbiter;

    localparam int MB = 512;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        P_Req = 0, P_RW = 0, P_SignExt = 0;
    logic [1:0]  P_Size = 0;
    logic [8:0]  P_Addr = 0;
    logic [31:0] P_WData = 0;
    logic        P_Ack, P_Err;
    logic [31:0] P_RData;
    logic        L_Req = 0, L_RW = 0, L_SignExt = 0;
    logic [1:0]  L_Size = 0;
    logic [8:0]  L_Addr = 0;
    logic [31:0] L_WData = 0;
    logic        L_Ack, L_Err;
    logic [31:0] L_RData;
    logic        MemEnable, MemReadWrite, MemSignExt;
    logic [1:0]  MemSize;
    logic [8:0]  MemAddress;
    logic [31:0] MemDataIn;
    logic [31:0] MemDataOut;
    logic        Busy;

    int checks = 0;
    int failures = 0;

    dmem_access_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_BYTES(MB)) dut (
        .Clk(Clk), .Reset(Reset),
        .P_Req(P_Req), .P_RW(P_RW), .P_SignExt(P_SignExt), .P_Size(P_Size),
        .P_Addr(P_Addr), .P_WData(P_WData), .P_Ack(P_Ack), .P_Err(P_Err), .P_RData(P_RData),
        .L_Req(L_Req), .L_RW(L_RW), .L_SignExt(L_SignExt), .L_Size(L_Size),
        .L_Addr(L_Addr), .L_WData(L_WData), .L_Ack(L_Ack), .L_Err(L_Err), .L_RData(L_RData),
        .MemEnable(MemEnable), .MemReadWrite(MemReadWrite), .MemSignExt(MemSignExt),
        .MemSize(MemSize), .MemAddress(MemAddress), .MemDataIn(MemDataIn),
        .MemDataOut(MemDataOut), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // DataMemory model: combinational read, write on the rising edge while enabled.
    logic [7:0] mem [0:MB-1];
    int a0;
    always_comb begin
        a0 = int'(MemAddress);
        MemDataOut = 32'h0;
        case (MemSize)
            2'b00: MemDataOut = MemSignExt ? {{24{mem[a0][7]}}, mem[a0]} : {24'h0, mem[a0]};
            2'b01: MemDataOut = MemSignExt ? {{16{mem[(a0+1)%MB][7]}}, mem[(a0+1)%MB], mem[a0]}
                                           : {16'h0, mem[(a0+1)%MB], mem[a0]};
            2'b10: MemDataOut = {mem[(a0+3)%MB], mem[(a0+2)%MB], mem[(a0+1)%MB], mem[a0]};
            default: MemDataOut = 32'h0;
        endcase
    end

    always @(posedge Clk) begin
        if (MemEnable && MemReadWrite) begin
            mem[int'(MemAddress)] <= MemDataIn[7:0];
            if (MemSize != 2'b00) mem[(int'(MemAddress)+1)%MB] <= MemDataIn[15:8];
            if (MemSize == 2'b10) begin
                mem[(int'(MemAddress)+2)%MB] <= MemDataIn[23:16];
                mem[(int'(MemAddress)+3)%MB] <= MemDataIn[31:24];
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_port(input logic port, input logic rw, input logic se,
                            input logic [1:0] size, input logic [8:0] addr, input logic [31:0] wd);
        if (port == 1'b0) begin
            P_RW = rw; P_SignExt = se; P_Size = size; P_Addr = addr; P_WData = wd; P_Req = 1'b1;
        end else begin
            L_RW = rw; L_SignExt = se; L_Size = size; L_Addr = addr; L_WData = wd; L_Req = 1'b1;
        end
    endtask

    // One access on one port; called 1 time unit after a rising edge with the FSM idle.
    task automatic xact(input logic port, input logic rw, input logic se, input logic [1:0] size,
                        input logic [8:0] addr, input logic [31:0] wd,
                        output int lat, output logic err, output logic [31:0] rd,
                        output logic saw_en, output logic both);
        lat = -1; err = 1'b0; rd = 32'h0; saw_en = 1'b0; both = 1'b0;
        set_port(port, rw, se, size, addr, wd);
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(posedge Clk); #1;
            if (MemEnable) saw_en = 1'b1;
            if (P_Ack && L_Ack) both = 1'b1;
            if (port == 1'b0 && P_Ack) begin lat = c; err = P_Err; rd = P_RData; end
            if (port == 1'b1 && L_Ack) begin lat = c; err = L_Err; rd = L_RData; end
        end
        P_Req = 1'b0;
        L_Req = 1'b0;
        @(posedge Clk); #1;
    endtask

    typedef struct {
        logic        port;
        logic        rw;
        logic        se;
        logic [1:0]  size;
        logic [8:0]  addr;
        logic [31:0] wdata;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int lat, pa, la, pa2, acks;
        logic err, saw_en, both;
        logic [31:0] rd;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 2'b00, 9'h005, 32'h0000_0080, 2, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'b00, 9'h005, 32'h0, 2, 1'b0, 32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 2'b00, 9'h005, 32'h0, 2, 1'b0, 32'h0000_0080};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'b10, 9'h020, 32'hA5A5_A5A5, 2, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'b10, 9'h020, 32'h0, 2, 1'b0, 32'hA5A5_A5A5};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'b10, 9'h1FE, 32'h1111_2222, 1, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'b11, 9'h000, 32'h0, 1, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'b10, 9'h012, 32'h1234_5678, ALIGN ? 1 : 2, ALIGN, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 2'b10, 9'h012, 32'h0, ALIGN ? 1 : 2, ALIGN,
                     ALIGN ? 32'h0 : 32'h1234_5678};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'b01, 9'h1FE, 32'h0000_BEEF, 2, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 2'b01, 9'h1FE, 32'h0, 2, 1'b0, 32'hFFFF_BEEF};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 2'b00, 9'h1FF, 32'h0, 2, 1'b0, 32'h0000_00BE};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 2'b10, 9'h1FD, 32'h0, 1, 1'b1, 32'h0};

        // Reset state.
        #2;
        check("rst_p_ack", {31'h0, P_Ack}, 32'h0);
        check("rst_l_ack", {31'h0, L_Ack}, 32'h0);
        check("rst_mem_en", {31'h0, MemEnable}, 32'h0);
        check("rst_busy", {31'h0, Busy}, 32'h0);
        check("rst_mem_addr", {23'h0, MemAddress}, 32'h0);
        check("rst_p_rdata", P_RData, 32'h0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Simultaneous requests after reset: P first, L three cycles later.
        pa = -1; la = -1; both = 1'b0;
        set_port(1'b0, 1'b0, 1'b0, 2'b00, 9'h000, 32'h0);
        set_port(1'b1, 1'b0, 1'b0, 2'b00, 9'h001, 32'h0);
        for (int c = 1; c <= 10; c++) begin
            @(posedge Clk); #1;
            if (P_Ack && L_Ack) both = 1'b1;
            if (P_Ack && pa < 0) begin pa = c; P_Req = 1'b0; end
            if (L_Ack && la < 0) begin la = c; L_Req = 1'b0; end
        end
        check("contend_p_lat", 32'(pa), 32'd2);
        check("contend_l_lat", 32'(la), 32'd5);
        check("contend_no_dual_ack", {31'h0, both}, 32'h0);

        for (int i = 0; i < 13; i++) begin
            xact(vecs[i].port, vecs[i].rw, vecs[i].se, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                 lat, err, rd, saw_en, both);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_mem_en", i), {31'h0, saw_en}, {31'h0, ~vecs[i].exp_err});
            check($sformatf("vec%0d_no_dual_ack", i), {31'h0, both}, 32'h0);
            check($sformatf("vec%0d_idle", i), {31'h0, Busy}, 32'h0);
        end

        // P holds Req across its Ack with L idle: re-granted, second Ack at cycle 5.
        pa = -1; pa2 = -1;
        set_port(1'b0, 1'b0, 1'b0, 2'b00, 9'h005, 32'h0);
        for (int c = 1; c <= 10 && pa2 < 0; c++) begin
            @(posedge Clk); #1;
            if (P_Ack && pa >= 0 && pa2 < 0) pa2 = c;
            if (P_Ack && pa < 0) pa = c;
        end
        P_Req = 1'b0;
        @(posedge Clk); #1;
        check("hold_first_ack", 32'(pa), 32'd2);
        check("hold_second_ack", 32'(pa2), 32'd5);

        // P holds Req while L becomes pending: L is served before P's second access.
        pa = -1; pa2 = -1; la = -1;
        set_port(1'b0, 1'b0, 1'b0, 2'b00, 9'h005, 32'h0);
        for (int c = 1; c <= 12 && pa2 < 0; c++) begin
            @(posedge Clk); #1;
            if (P_Ack && pa >= 0 && pa2 < 0) pa2 = c;
            if (P_Ack && pa < 0) begin
                pa = c;
                set_port(1'b1, 1'b0, 1'b0, 2'b10, 9'h020, 32'h0);
            end
            if (L_Ack && la < 0) begin
                la = c;
                check("rr_l_rdata", L_RData, 32'hA5A5_A5A5);
                L_Req = 1'b0;
            end
        end
        P_Req = 1'b0;
        L_Req = 1'b0;
        @(posedge Clk); #1;
        check("rr_p_first", 32'(pa), 32'd2);
        check("rr_l_ack", 32'(la), 32'd5);
        check("rr_p_second", 32'(pa2), 32'd8);

        // Reset pulsed during ACCESS.
        set_port(1'b0, 1'b1, 1'b0, 2'b10, 9'h040, 32'hDEAD_BEEF);
        @(posedge Clk); #1;
        check("rstmid_mem_en_before", {31'h0, MemEnable}, 32'h1);
        check("rstmid_busy_before", {31'h0, Busy}, 32'h1);
        #2;
        Reset = 1'b1;
        P_Req = 1'b0;
        #1;
        check("rstmid_mem_en", {31'h0, MemEnable}, 32'h0);
        check("rstmid_busy", {31'h0, Busy}, 32'h0);
        #2;
        Reset = 1'b0;
        acks = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge Clk); #1;
            if (P_Ack || L_Ack) acks++;
        end
        check("rstmid_no_ack", 32'(acks), 32'd0);
        xact(1'b0, 1'b0, 1'b0, 2'b10, 9'h020, 32'h0, lat, err, rd, saw_en, both);
        check("rstmid_next_lat", 32'(lat), 32'd2);
        check("rstmid_next_rdata", rd, 32'hA5A5_A5A5);
        check("rstmid_next_err", {31'h0, err}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
